// File: rtl/alu_exec_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_exec_sequencer_if: decode/ALU/writeback bundle of the execute sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_exec_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [2:0]       in_func3;
  logic             in_ir30;
  logic [WIDTH-1:0] in_rs1;
  logic [WIDTH-1:0] in_rs2;
  logic [WIDTH-1:0] in_imm;
  logic [WIDTH-1:0] in_pc;
  logic [4:0]       in_rd;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_rd;
  logic             out_we;
  logic             out_branch_taken;
  logic [WIDTH-1:0] out_target;
  logic             out_illegal;
  logic             busy;

  modport slave (
    input  in_valid, in_opcode, in_func3, in_ir30, in_rs1, in_rs2, in_imm, in_pc, in_rd,
    input  alu_result, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_op,
    output out_valid, out_result, out_rd, out_we, out_branch_taken, out_target, out_illegal, busy
  );

  modport master (
    output in_valid, in_opcode, in_func3, in_ir30, in_rs1, in_rs2, in_imm, in_pc, in_rd,
    output alu_result, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_op,
    input  out_valid, out_result, out_rd, out_we, out_branch_taken, out_target, out_illegal, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_exec_sequencer.sv
// ----------------------------------------------------------------------------
// alu_exec_sequencer: multi-cycle execute controller driving a shared ALU.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_exec_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_exec_sequencer_if.slave  bus
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_TGT  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             alive_q;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, pc_q, pc_d, imm_q, imm_d;
  logic             branch_q, branch_d, br_zero_q, br_zero_d, br_inv_q, br_inv_d;
  logic [WIDTH-1:0] out_result_q, out_result_d, out_target_q, out_target_d;
  logic             out_taken_q, out_taken_d, out_we_q, out_we_d, out_illegal_q, out_illegal_d;
  logic [4:0]       out_rd_q, out_rd_d;

  logic [3:0]       dec_op;
  logic [WIDTH-1:0] dec_a, dec_b;
  logic             dec_illegal, dec_branch, dec_wb;
  logic             cond;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_op;

  always_comb begin
    dec_op      = ALU_ADD;
    dec_a       = bus.in_rs1;
    dec_b       = bus.in_rs2;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    dec_wb      = 1'b0;
    case (bus.in_opcode)
      OPC_R, OPC_I: begin
        dec_wb = 1'b1;
        if (bus.in_opcode == OPC_I) dec_b = bus.in_imm;
        // ir30 selects SUB only for register ADD; ADDI has no SUB form
        case (bus.in_func3)
          3'b000:  dec_op = (bus.in_ir30 && bus.in_opcode == OPC_R) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_op = ALU_SLL;
          3'b010:  dec_op = ALU_SLT;
          3'b011:  dec_op = ALU_SLTU;
          3'b100:  dec_op = ALU_XOR;
          3'b101:  dec_op = bus.in_ir30 ? ALU_SRA : ALU_SRL;
          3'b110:  dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec_wb = 1'b1;
        dec_a  = '0;
        dec_b  = bus.in_imm;
      end
      OPC_AUIPC: begin
        dec_wb = 1'b1;
        dec_a  = bus.in_pc;
        dec_b  = bus.in_imm;
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        case (bus.in_func3[2:1])
          2'b00:   dec_op = ALU_SUB;
          2'b01:   dec_illegal = 1'b1;
          2'b10:   dec_op = ALU_SLT;
          default: dec_op = ALU_SLTU;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Equality branches test alu_zero, ordered ones test the set-less-than bit;
  // func3[0] inverts the sense (BNE/BGE/BGEU).
  assign cond = br_zero_q ? bus.alu_zero : bus.alu_result[0];

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    branch_d      = branch_q;
    br_zero_d     = br_zero_q;
    br_inv_d      = br_inv_q;
    out_result_d  = out_result_q;
    out_target_d  = out_target_q;
    out_taken_d   = out_taken_q;
    out_we_d      = out_we_q;
    out_illegal_d = out_illegal_q;
    out_rd_d      = out_rd_q;
    alu_a         = '0;
    alu_b         = '0;
    alu_op        = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && alive_q) begin
          op_d          = dec_op;
          a_d           = dec_a;
          b_d           = dec_b;
          pc_d          = bus.in_pc;
          imm_d         = bus.in_imm;
          branch_d      = dec_branch;
          br_zero_d     = ~bus.in_func3[2];
          br_inv_d      = bus.in_func3[0];
          out_result_d  = '0;
          out_target_d  = '0;
          out_taken_d   = 1'b0;
          out_rd_d      = bus.in_rd;
          out_illegal_d = dec_illegal;
          out_we_d      = dec_wb && (bus.in_rd != 5'd0);
          state_d       = dec_illegal ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = op_q;
        if (branch_q) begin
          out_taken_d = cond ^ br_inv_q;
          state_d     = S_TGT;
        end else begin
          out_result_d = bus.alu_result;
          state_d      = S_RESP;
        end
      end
      S_TGT: begin
        alu_a        = pc_q;
        alu_b        = imm_q;
        alu_op       = ALU_ADD;
        out_target_d = bus.alu_result;
        state_d      = S_RESP;
      end
      default: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      alive_q       <= 1'b0;
      op_q          <= 4'b0000;
      a_q           <= '0;
      b_q           <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      branch_q      <= 1'b0;
      br_zero_q     <= 1'b0;
      br_inv_q      <= 1'b0;
      out_result_q  <= '0;
      out_target_q  <= '0;
      out_taken_q   <= 1'b0;
      out_we_q      <= 1'b0;
      out_illegal_q <= 1'b0;
      out_rd_q      <= 5'd0;
    end else begin
      state_q       <= state_d;
      alive_q       <= 1'b1;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      branch_q      <= branch_d;
      br_zero_q     <= br_zero_d;
      br_inv_q      <= br_inv_d;
      out_result_q  <= out_result_d;
      out_target_q  <= out_target_d;
      out_taken_q   <= out_taken_d;
      out_we_q      <= out_we_d;
      out_illegal_q <= out_illegal_d;
      out_rd_q      <= out_rd_d;
    end
  end

  assign bus.in_ready         = alive_q && (state_q == S_IDLE);
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.out_valid        = (state_q == S_RESP);
  assign bus.out_result       = out_result_q;
  assign bus.out_target       = out_target_q;
  assign bus.out_branch_taken = out_taken_q;
  assign bus.out_we           = out_we_q;
  assign bus.out_illegal      = out_illegal_q;
  assign bus.out_rd           = out_rd_q;
  assign bus.alu_a            = alu_a;
  assign bus.alu_b            = alu_b;
  assign bus.alu_op           = alu_op;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_sequencer: random + directed instructions against a semantic model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_exec_sequencer;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_exec_sequencer_if #(.WIDTH(32)) bus ();

  alu_exec_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External ALU, straight from the ALUOp table
  logic [31:0] alu_res;
  always_comb begin
    alu_res = 32'd0;
    case (bus.alu_op)
      4'd0: alu_res = bus.alu_a + bus.alu_b;
      4'd1: alu_res = bus.alu_a - bus.alu_b;
      4'd2: alu_res = bus.alu_a & bus.alu_b;
      4'd3: alu_res = bus.alu_a | bus.alu_b;
      4'd4: alu_res = bus.alu_a ^ bus.alu_b;
      4'd5: alu_res = bus.alu_a << bus.alu_b[4:0];
      4'd6: alu_res = bus.alu_a >> bus.alu_b[4:0];
      4'd7: alu_res = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      4'd8: alu_res = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      4'd9: alu_res = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_zero   = (alu_res == 32'd0);

  typedef struct {
    logic [31:0] res;
    logic [31:0] tgt;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        we;
    logic        taken;
    logic        ill;
    logic        br;
    int          lat;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic ir30,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    exp_t e;
    logic [31:0] b;
    e.res = 32'd0; e.tgt = 32'd0; e.a = rs1; e.b = rs2; e.op = 4'd0;
    e.we = 1'b0; e.taken = 1'b0; e.ill = 1'b0; e.br = 1'b0; e.lat = 2;
    if (opc == OPC_R || opc == OPC_I) begin
      b   = (opc == OPC_R) ? rs2 : imm;
      e.b = b;
      case (f3)
        3'd0: begin
          if (opc == OPC_R && ir30) begin e.res = rs1 - b; e.op = 4'd1; end
          else                      begin e.res = rs1 + b; e.op = 4'd0; end
        end
        3'd1: begin e.res = rs1 << b[4:0]; e.op = 4'd5; end
        3'd2: begin e.res = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0; e.op = 4'd8; end
        3'd3: begin e.res = (rs1 < b) ? 32'd1 : 32'd0; e.op = 4'd9; end
        3'd4: begin e.res = rs1 ^ b; e.op = 4'd4; end
        3'd5: begin
          if (ir30) begin e.res = $unsigned($signed(rs1) >>> b[4:0]); e.op = 4'd7; end
          else      begin e.res = rs1 >> b[4:0]; e.op = 4'd6; end
        end
        3'd6: begin e.res = rs1 | b; e.op = 4'd3; end
        default: begin e.res = rs1 & b; e.op = 4'd2; end
      endcase
      e.we = (rd != 5'd0);
    end else if (opc == OPC_LUI) begin
      e.a = 32'd0; e.b = imm; e.res = imm; e.we = (rd != 5'd0);
    end else if (opc == OPC_AUIPC) begin
      e.a = pc; e.b = imm; e.res = pc + imm; e.we = (rd != 5'd0);
    end else if (opc == OPC_BRANCH && f3 != 3'd2 && f3 != 3'd3) begin
      e.br = 1'b1; e.lat = 3; e.tgt = pc + imm;
      case (f3)
        3'd0: begin e.taken = (rs1 == rs2); e.op = 4'd1; end
        3'd1: begin e.taken = (rs1 != rs2); e.op = 4'd1; end
        3'd4: begin e.taken = ($signed(rs1) <  $signed(rs2)); e.op = 4'd8; end
        3'd5: begin e.taken = ($signed(rs1) >= $signed(rs2)); e.op = 4'd8; end
        3'd6: begin e.taken = (rs1 <  rs2); e.op = 4'd9; end
        default: begin e.taken = (rs1 >= rs2); e.op = 4'd9; end
      endcase
    end else begin
      e.ill = 1'b1; e.lat = 1;
    end
    return e;
  endfunction

  task automatic scramble_inputs();
    bus.in_opcode = 7'($urandom);
    bus.in_func3  = 3'($urandom);
    bus.in_ir30   = 1'($urandom);
    bus.in_rs1    = $urandom;
    bus.in_rs2    = $urandom;
    bus.in_imm    = $urandom;
    bus.in_pc     = $urandom;
    bus.in_rd     = 5'($urandom);
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic ir30,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [4:0] rd, input int hold);
    exp_t e;
    int   n;
    int   lat;
    e = model(opc, f3, ir30, rs1, rs2, imm, pc, rd);
    bus.in_valid = 1'b1; bus.in_opcode = opc; bus.in_func3 = f3; bus.in_ir30 = ir30;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm; bus.in_pc = pc; bus.in_rd = rd;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      if (lat == 1) begin
        chk("exec_op", {28'd0, bus.alu_op}, {28'd0, e.op});
        chk("exec_a", bus.alu_a, e.a);
        chk("exec_b", bus.alu_b, e.b);
      end
      if (lat == 2 && e.br) begin
        chk("tgt_op", {28'd0, bus.alu_op}, 32'd0);
        chk("tgt_a", bus.alu_a, pc);
        chk("tgt_b", bus.alu_b, imm);
      end
      bus.out_ready = 1'($urandom);
      bus.in_valid  = 1'($urandom);
      scramble_inputs();
      @(posedge clk); #1; lat++;
    end
    bus.out_ready = 1'b0;
    chk("latency", 32'(lat), 32'(e.lat));
    if (!bus.out_valid) begin
      bus.in_valid = 1'b0;
      return;
    end
    for (int h = 0; h <= hold; h++) begin
      chk("out_result", bus.out_result, e.res);
      chk("out_target", bus.out_target, e.tgt);
      chk("out_taken", {31'd0, bus.out_branch_taken}, {31'd0, e.taken});
      chk("out_we", {31'd0, bus.out_we}, {31'd0, e.we});
      chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, e.ill});
      chk("out_rd", {27'd0, bus.out_rd}, {27'd0, rd});
      chk("resp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("resp_alu_op", {28'd0, bus.alu_op}, 32'd0);
      chk("resp_valid", {31'd0, bus.out_valid}, 32'd1);
      if (h < hold) begin
        bus.in_valid = 1'($urandom);
        scramble_inputs();
        @(posedge clk); #1;
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_hs_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_hs_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_alu_op"}, {28'd0, bus.alu_op}, 32'd0);
    chk({tag, "_alu_a"}, bus.alu_a, 32'd0);
    chk({tag, "_out_result"}, bus.out_result, 32'd0);
    chk({tag, "_out_we"}, {31'd0, bus.out_we}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  opc;
    logic [31:0] r1;
    logic [31:0] r2;
    int          k;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel_ready_before_clk", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_ready_after_clk", {31'd0, bus.in_ready}, 32'd1);

    run_instr(OPC_R, 3'd0, 1'b1, 32'd10, 32'd3, $urandom, $urandom, 5'd5, 0);
    run_instr(OPC_I, 3'd5, 1'b1, 32'h8000_0000, $urandom, 32'd4, $urandom, 5'd7, 0);
    run_instr(OPC_I, 3'd5, 1'b0, 32'h8000_0000, $urandom, 32'd4, $urandom, 5'd7, 0);
    run_instr(OPC_BRANCH, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd3, 0);
    run_instr(OPC_BRANCH, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd3, 0);
    run_instr(OPC_R, 3'd0, 1'b0, 32'd5, 32'd6, $urandom, $urandom, 5'd9, 5);
    run_instr(OPC_LOAD, 3'd2, 1'b0, $urandom, $urandom, $urandom, $urandom, 5'd4, 1);
    run_instr(OPC_I, 3'd0, 1'b1, 32'd5, $urandom, 32'd6, $urandom, 5'd0, 0);
    run_instr(OPC_BRANCH, 3'd2, 1'b0, $urandom, $urandom, $urandom, $urandom, 5'd1, 0);

    // Reset while the instruction sits in EXEC
    bus.in_valid = 1'b1; bus.in_opcode = OPC_R; bus.in_func3 = 3'd0; bus.in_ir30 = 1'b0;
    bus.in_rs1 = 32'd1; bus.in_rs2 = 32'd2; bus.in_rd = 5'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    chk("reset_hold_valid", {31'd0, bus.out_valid}, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("rel2_ready_before_clk", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel2_ready_after_clk", {31'd0, bus.in_ready}, 32'd1);
    chk("rel2_no_resp", {31'd0, bus.out_valid}, 32'd0);
    run_instr(OPC_R, 3'd0, 1'b0, 32'd100, 32'd23, $urandom, $urandom, 5'd2, 0);

    for (int i = 0; i < 120; i++) begin
      k  = $urandom_range(0, 5);
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      case (k)
        0: opc = OPC_R;
        1: opc = OPC_I;
        2: opc = OPC_LUI;
        3: opc = OPC_AUIPC;
        4: opc = OPC_BRANCH;
        default: begin
          do opc = 7'($urandom);
          while (opc == OPC_R || opc == OPC_I || opc == OPC_LUI ||
                 opc == OPC_AUIPC || opc == OPC_BRANCH);
        end
      endcase
      run_instr(opc, 3'($urandom), 1'($urandom), r1, r2,
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom,
                $urandom, 5'($urandom), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
